// File: rtl/pong_pkg.sv
// pong_pkg: types and constants shared by the Pong match sequencer.
//   game_state_t  2-bit match state as seen by the renderer
//   score_t       4-bit player score
//   score_inc()   score increment that saturates at 15
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    SCORED    = 2'd2,
    GAME_OVER = 2'd3
  } game_state_t;

  typedef logic [3:0] score_t;

  localparam int     DEFAULT_WIN_SCORE          = 10;
  localparam int     DEFAULT_SCORE_PAUSE_FRAMES = 60;
  localparam score_t SCORE_MAX                  = 4'd15;

  function automatic score_t score_inc(input score_t s);
    return (s == SCORE_MAX) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// pong_frame_timer: loadable down-counter advanced by the per-frame tick.
//   clk, rst    clock, asynchronous active-low reset
//   load        load count with load_value (wins over tick)
//   load_value  frames to wait
//   tick        decrement enable, one pulse per frame
//   count       current remaining frames
//   done        combinational pulse on the tick that takes count 1 -> 0, so
//               the owner can react on the same edge the count expires
module pong_frame_timer #(
  parameter  int MAX_COUNT = 60,
  localparam int W         = $clog2(MAX_COUNT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         done
);

  assign done = tick && !load && (count == W'(1));

  // NOTE: this is control state, not storage, so it takes the async reset;
  // every sequential assignment is non-blocking to avoid simulation races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && (count != '0)) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong match sequencer (idle / play / point pause / game over).
//   clk, rst        65 MHz clock, asynchronous active-low reset
//   timing_tick     one pulse per video frame, paces the between-point pause
//   start           start / restart a match from IDLE or GAME_OVER
//   p1_goal         point to player 1 (wins over a simultaneous p2_goal)
//   p2_goal         point to player 2
//   pause           pause toggle, only used when PONG_PAUSE_EN is defined
//   state           game_state_t encoding
//   player1_score   player 1 score
//   player2_score   player 2 score
//   ball_rst        one-cycle re-centre-and-launch pulse
//   serve_dir       0 = serve left (player 1), 1 = serve right (player 2)
//   still_graphic   freeze motion (everywhere except un-paused PLAY)
//   paused          play is paused (tied 0 unless PONG_PAUSE_EN is defined)
// Optional feature macro: PONG_PAUSE_EN.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE          = DEFAULT_WIN_SCORE,
  parameter int SCORE_PAUSE_FRAMES = DEFAULT_SCORE_PAUSE_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic        start,
  input  logic        p1_goal,
  input  logic        p2_goal,
  input  logic        pause,
  output game_state_t state,
  output score_t      player1_score,
  output score_t      player2_score,
  output logic        ball_rst,
  output logic        serve_dir,
  output logic        still_graphic,
  output logic        paused
);

  localparam int     TW        = $clog2(SCORE_PAUSE_FRAMES + 1);
  localparam score_t WIN_VALUE = score_t'(WIN_SCORE);

  logic          goal_take;
  logic          win;
  logic          pause_toggle;
  logic          timer_done;
  logic [TW-1:0] timer_count;
  score_t        p1_next;
  score_t        p2_next;

  assign p1_next   = score_inc(player1_score);
  assign p2_next   = score_inc(player2_score);
  assign goal_take = (state == PLAY) && !paused && (p1_goal || p2_goal);
  assign win       = p1_goal ? (p1_next == WIN_VALUE) : (p2_next == WIN_VALUE);

`ifdef PONG_PAUSE_EN
  // A goal in the same cycle leaves PLAY, which clears paused anyway.
  assign pause_toggle = (state == PLAY) && pause && !goal_take;
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_toggle = 1'b0;
`endif

  // Ticks only count while SCORED, so a tick coincident with the goal is lost.
  pong_frame_timer #(
    .MAX_COUNT (SCORE_PAUSE_FRAMES)
  ) u_frame_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (goal_take && !win),
    .load_value (TW'(SCORE_PAUSE_FRAMES)),
    .tick       (timing_tick && (state == SCORED)),
    .count      (timer_count),
    .done       (timer_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      player1_score <= '0;
      player2_score <= '0;
      ball_rst      <= 1'b0;
      serve_dir     <= 1'b0;
      still_graphic <= 1'b1;
      paused        <= 1'b0;
    end else begin
      ball_rst <= 1'b0;
      case (state)
        IDLE, GAME_OVER: begin
          if (start) begin
            player1_score <= '0;
            player2_score <= '0;
            serve_dir     <= 1'b0;
            state         <= PLAY;
            ball_rst      <= 1'b1;
            still_graphic <= 1'b0;
          end
        end
        PLAY: begin
          if (goal_take) begin
            // Serve goes toward the player who conceded.
            if (p1_goal) begin
              player1_score <= p1_next;
              serve_dir     <= 1'b1;
            end else begin
              player2_score <= p2_next;
              serve_dir     <= 1'b0;
            end
            state         <= win ? GAME_OVER : SCORED;
            still_graphic <= 1'b1;
            paused        <= 1'b0;
          end else if (pause_toggle) begin
            paused        <= !paused;
            still_graphic <= !paused;
          end
        end
        SCORED: begin
          if (timer_done) begin
            state         <= PLAY;
            ball_rst      <= 1'b1;
            still_graphic <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed bench for pong_game_ctrl with a rule-level
// reference model compared against the DUT on every active cycle.
module tb_pong_game_ctrl;

  localparam int WIN    = 10;
  localparam int FRAMES = 60;
`ifdef PONG_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       timing_tick = 1'b0;
  logic       start = 1'b0;
  logic       p1_goal = 1'b0;
  logic       p2_goal = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] state;
  logic [3:0] player1_score;
  logic [3:0] player2_score;
  logic       ball_rst;
  logic       serve_dir;
  logic       still_graphic;
  logic       paused;

  int checks   = 0;
  int failures = 0;

  pong_game_ctrl #(
    .WIN_SCORE          (WIN),
    .SCORE_PAUSE_FRAMES (FRAMES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .timing_tick   (timing_tick),
    .start         (start),
    .p1_goal       (p1_goal),
    .p2_goal       (p2_goal),
    .pause         (pause),
    .state         (state),
    .player1_score (player1_score),
    .player2_score (player2_score),
    .ball_rst      (ball_rst),
    .serve_dir     (serve_dir),
    .still_graphic (still_graphic),
    .paused        (paused)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: match rules applied once per clock to the sampled pulses.
  // States: 0 idle, 1 play, 2 point pause, 3 game over.
  int m_state, m_s1, m_s2, m_frames_left;
  bit m_brst, m_dir, m_paused;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state = 0; m_s1 = 0; m_s2 = 0; m_frames_left = 0;
      m_brst = 0; m_dir = 0; m_paused = 0;
    end else begin
      bit won;
      m_brst = 0;
      if ((m_state == 0 || m_state == 3) && start) begin
        m_s1 = 0; m_s2 = 0; m_dir = 0; m_state = 1; m_brst = 1;
      end else if (m_state == 1 && !m_paused && (p1_goal || p2_goal)) begin
        if (p1_goal) begin
          m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15;
          m_dir = 1;
          won = (m_s1 == WIN);
        end else begin
          m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15;
          m_dir = 0;
          won = (m_s2 == WIN);
        end
        m_paused = 0;
        if (won) m_state = 3;
        else begin
          m_state = 2;
          m_frames_left = FRAMES;
        end
      end else if (m_state == 1 && PAUSE_EN && pause) begin
        m_paused = !m_paused;
      end else if (m_state == 2 && timing_tick) begin
        m_frames_left--;
        if (m_frames_left == 0) begin
          m_state = 1;
          m_brst = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("state", state, m_state);
      check("p1_score", player1_score, m_s1);
      check("p2_score", player2_score, m_s2);
      check("ball_rst", ball_rst, m_brst);
      check("serve_dir", serve_dir, m_dir);
      check("still_graphic", still_graphic, !(m_state == 1 && !m_paused));
      check("paused", paused, m_paused);
    end
  end

  // Apply one cycle of inputs at a falling edge; returns at the next falling
  // edge, where the outputs reflect that cycle.
  task automatic step(input bit tk, input bit st, input bit g1, input bit g2, input bit ps);
    timing_tick = tk; start = st; p1_goal = g1; p2_goal = g2; pause = ps;
    @(negedge clk);
    timing_tick = 0; start = 0; p1_goal = 0; p2_goal = 0; pause = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_state", state, 0);
    check("rst_scores", {player1_score, player2_score}, 0);
    check("rst_still", still_graphic, 1);
    check("rst_ball_rst", ball_rst, 0);
    check("rst_dir", serve_dir, 0);
    check("rst_paused", paused, 0);
    rst = 1;
    idle(2);

    // Start from IDLE
    step(0, 1, 0, 0, 0);
    check("start_state", state, 1);
    check("start_ball_rst", ball_rst, 1);
    check("start_still", still_graphic, 0);
    idle(1);
    check("start_ball_rst_drop", ball_rst, 0);
    step(0, 1, 0, 0, 0);
    check("start_in_play_ignored", {state, 3'(ball_rst)}, {2'd1, 3'd0});

    // Point to player 2, then the pause between points
    step(0, 0, 0, 1, 0);
    check("p2_goal_score", player2_score, 1);
    check("p2_goal_state", state, 2);
    check("p2_goal_dir", serve_dir, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    check("scored_goals_ignored", {player1_score, player2_score}, 8'h01);
    check("scored_start_ignored", state, 2);
    ticks(FRAMES - 1);
    check("scored_59_ticks", state, 2);
    step(1, 0, 0, 0, 0);
    check("scored_60th_state", state, 1);
    check("scored_60th_ball_rst", ball_rst, 1);

    // Player 1 to nine points, then the winning point
    for (int i = 0; i < WIN - 1; i++) begin
      step(0, 0, 1, 0, 0);
      ticks(FRAMES);
    end
    check("p1_nine", player1_score, 9);
    step(0, 0, 1, 0, 0);
    check("win_score", player1_score, 10);
    check("win_state", state, 3);
    check("win_still", still_graphic, 1);
    idle(3);
    check("game_over_hold", {player1_score, player2_score}, 8'hA1);
    step(0, 1, 0, 0, 0);
    check("restart_scores", {player1_score, player2_score}, 0);
    check("restart_state", state, 1);
    check("restart_ball_rst", ball_rst, 1);

    // Simultaneous goals: player 1 wins the point
    idle(1);
    step(0, 0, 1, 1, 0);
    check("both_goal_scores", {player1_score, player2_score}, 8'h10);
    check("both_goal_dir", serve_dir, 1);

    // Asynchronous reset while the counter is at 30
    ticks(30);
    check("pre_reset_state", state, 2);
    #3 rst = 0;
    #1;
    check("async_rst_state", state, 0);
    check("async_rst_scores", {player1_score, player2_score}, 0);
    check("async_rst_still", still_graphic, 1);
    @(negedge clk);
    idle(1);
    rst = 1;
    idle(2);
    step(0, 1, 0, 0, 0);
    check("post_reset_start", state, 1);

`ifdef PONG_PAUSE_EN
    idle(1);
    step(0, 0, 0, 0, 1);
    check("pause_on", paused, 1);
    check("pause_still", still_graphic, 1);
    step(0, 0, 1, 0, 0);
    check("pause_goal_ignored", player1_score, 0);
    step(0, 0, 0, 0, 1);
    check("pause_off", paused, 0);
    check("pause_off_still", still_graphic, 0);
    check("pause_off_no_ball_rst", ball_rst, 0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    check("pause_again", paused, 1);
`endif
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
